// File: rtl/mano_ac_exec_pkg.sv
// Shared constants for the MANO AC execution sequencer.
// Holds the default data/func widths, the ALU func codes and the AC-side
// micro-operation codes presented by the control unit.
package mano_ac_exec_pkg;

  localparam int unsigned AC_DATAWIDTH = 16;
  localparam int unsigned AC_FUNCWIDTH = 4;

  // ALU func codes
  localparam logic [AC_FUNCWIDTH-1:0] NO_FUNC     = 4'd0;
  localparam logic [AC_FUNCWIDTH-1:0] AND_FUNC    = 4'd1;
  localparam logic [AC_FUNCWIDTH-1:0] ADD_FUNC    = 4'd2;
  localparam logic [AC_FUNCWIDTH-1:0] PASSDR_FUNC = 4'd3;
  localparam logic [AC_FUNCWIDTH-1:0] CMA_FUNC    = 4'd4;
  localparam logic [AC_FUNCWIDTH-1:0] CME_FUNC    = 4'd5;
  localparam logic [AC_FUNCWIDTH-1:0] CIR_FUNC    = 4'd6;
  localparam logic [AC_FUNCWIDTH-1:0] CIL_FUNC    = 4'd7;

  // AC-side operation codes; 15 is reserved and behaves as NOP
  localparam logic [3:0] AC_OP_NOP = 4'd0;
  localparam logic [3:0] AC_OP_AND = 4'd1;
  localparam logic [3:0] AC_OP_ADD = 4'd2;
  localparam logic [3:0] AC_OP_LDA = 4'd3;
  localparam logic [3:0] AC_OP_CLA = 4'd4;
  localparam logic [3:0] AC_OP_CLE = 4'd5;
  localparam logic [3:0] AC_OP_CMA = 4'd6;
  localparam logic [3:0] AC_OP_CME = 4'd7;
  localparam logic [3:0] AC_OP_CIR = 4'd8;
  localparam logic [3:0] AC_OP_CIL = 4'd9;
  localparam logic [3:0] AC_OP_INC = 4'd10;
  localparam logic [3:0] AC_OP_SPA = 4'd11;
  localparam logic [3:0] AC_OP_SNA = 4'd12;
  localparam logic [3:0] AC_OP_SZA = 4'd13;
  localparam logic [3:0] AC_OP_SZE = 4'd14;

endpackage

// File: rtl/mano_ac_op_decode.sv
// Combinational decode of an AC-side op code into ALU func and writeback controls.
// Ports:
//   op_i          operation code
//   alu_func_o    func code driven to the ALU during EXEC
//   force_a_one_o replace the DR operand with 1 (INC)
//   wr_ac_o       AC <= ALU z
//   wr_e_o        E  <= ALU e_out
//   clr_ac_o      AC <= 0
//   clr_e_o       E  <= 0
//   is_skip_o     op is one of the skip tests
module mano_ac_op_decode
  import mano_ac_exec_pkg::*;
#(
  parameter int unsigned FuncWidth = AC_FUNCWIDTH
) (
  input  logic [3:0]           op_i,
  output logic [FuncWidth-1:0] alu_func_o,
  output logic                 force_a_one_o,
  output logic                 wr_ac_o,
  output logic                 wr_e_o,
  output logic                 clr_ac_o,
  output logic                 clr_e_o,
  output logic                 is_skip_o
);

  always_comb begin
    alu_func_o    = FuncWidth'(NO_FUNC);
    force_a_one_o = 1'b0;
    wr_ac_o       = 1'b0;
    wr_e_o        = 1'b0;
    clr_ac_o      = 1'b0;
    clr_e_o       = 1'b0;
    is_skip_o     = 1'b0;
    unique case (op_i)
      AC_OP_AND: begin alu_func_o = FuncWidth'(AND_FUNC);    wr_ac_o = 1'b1; end
      AC_OP_ADD: begin
        alu_func_o = FuncWidth'(ADD_FUNC);
        wr_ac_o    = 1'b1;
        wr_e_o     = 1'b1;
      end
      AC_OP_LDA: begin alu_func_o = FuncWidth'(PASSDR_FUNC); wr_ac_o = 1'b1; end
      AC_OP_CLA: clr_ac_o = 1'b1;
      AC_OP_CLE: clr_e_o  = 1'b1;
      AC_OP_CMA: begin alu_func_o = FuncWidth'(CMA_FUNC);    wr_ac_o = 1'b1; end
      AC_OP_CME: begin alu_func_o = FuncWidth'(CME_FUNC);    wr_e_o  = 1'b1; end
      AC_OP_CIR: begin
        alu_func_o = FuncWidth'(CIR_FUNC);
        wr_ac_o    = 1'b1;
        wr_e_o     = 1'b1;
      end
      AC_OP_CIL: begin
        alu_func_o = FuncWidth'(CIL_FUNC);
        wr_ac_o    = 1'b1;
        wr_e_o     = 1'b1;
      end
      // INC reuses the adder with a=1; carry is deliberately dropped
      AC_OP_INC: begin
        alu_func_o    = FuncWidth'(ADD_FUNC);
        force_a_one_o = 1'b1;
        wr_ac_o       = 1'b1;
      end
      AC_OP_SPA, AC_OP_SNA, AC_OP_SZA, AC_OP_SZE: is_skip_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mano_ac_exec.sv
// Execution sequencer around the combinational MANO ALU. Owns AC and E, drives the
// ALU from registered operands, writes results back and evaluates skip tests.
// Sequence per request: IDLE (accept) -> EXEC (ALU busy, writeback) -> DONE (done=1).
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_op, req_dr        op code and DR operand, sampled on accept
//   alu_a/b/e_in/func     registered ALU inputs
//   alu_z, alu_e_out      ALU results
//   ac, e                 architectural accumulator and E flip-flop
//   done, skip            completion pulse and skip result (valid with done)
//   ovf, ovf_clr          sticky signed-overflow flag and its clear, present only
//                         when MANO_AC_OVF_FLAG_EN is defined
module mano_ac_exec
  import mano_ac_exec_pkg::*;
#(
  parameter int unsigned DATAWIDTH = AC_DATAWIDTH,
  parameter int unsigned FUNCWIDTH = AC_FUNCWIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [3:0]           req_op,
  input  logic [DATAWIDTH-1:0] req_dr,
  output logic [DATAWIDTH-1:0] alu_a,
  output logic [DATAWIDTH-1:0] alu_b,
  output logic                 alu_e_in,
  output logic [FUNCWIDTH-1:0] alu_func,
  input  logic [DATAWIDTH-1:0] alu_z,
  input  logic                 alu_e_out,
  output logic [DATAWIDTH-1:0] ac,
  output logic                 e,
  output logic                 done,
`ifdef MANO_AC_OVF_FLAG_EN
  input  logic                 ovf_clr,
  output logic                 ovf,
`endif
  output logic                 skip
);

  localparam int unsigned Msb = DATAWIDTH - 1;

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             op_q, op_d;
  logic [DATAWIDTH-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic                   alu_e_in_q, alu_e_in_d;
  logic [FUNCWIDTH-1:0]   alu_func_q, alu_func_d;
  logic [DATAWIDTH-1:0]   ac_q, ac_d;
  logic                   e_q, e_d;
  logic                   skip_q, skip_d;

  logic [3:0]             dec_op;
  logic [FUNCWIDTH-1:0]   dec_func;
  logic                   dec_force_a_one, dec_wr_ac, dec_wr_e, dec_clr_ac, dec_clr_e;
  logic                   dec_is_skip;

  // In IDLE decode the incoming op (to load func/operands); afterwards the latched one
  assign dec_op = (state_q == StIdle) ? req_op : op_q;

  mano_ac_op_decode #(
    .FuncWidth (FUNCWIDTH)
  ) u_decode (
    .op_i          (dec_op),
    .alu_func_o    (dec_func),
    .force_a_one_o (dec_force_a_one),
    .wr_ac_o       (dec_wr_ac),
    .wr_e_o        (dec_wr_e),
    .clr_ac_o      (dec_clr_ac),
    .clr_e_o       (dec_clr_e),
    .is_skip_o     (dec_is_skip)
  );

`ifdef MANO_AC_OVF_FLAG_EN
  logic ovf_q, ovf_d;
  logic ovf_set;

  // Signed overflow: operands agree in sign, result sign differs
  assign ovf_set = (state_q == StExec) && (op_q == AC_OP_ADD) &&
                   (alu_a_q[Msb] == alu_b_q[Msb]) && (alu_z[Msb] != alu_a_q[Msb]);

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;  // set beats a simultaneous clear
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_e_in_d = alu_e_in_q;
    alu_func_d = FUNCWIDTH'(NO_FUNC);
    ac_d       = ac_q;
    e_d        = e_q;
    skip_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d    = StExec;
          op_d       = req_op;
          alu_a_d    = dec_force_a_one ? DATAWIDTH'(1) : req_dr;
          alu_b_d    = ac_q;
          alu_e_in_d = e_q;
          alu_func_d = dec_func;
        end
      end
      StExec: begin
        state_d = StDone;
        if (dec_clr_ac) ac_d = '0;
        if (dec_wr_ac)  ac_d = alu_z;
        if (dec_clr_e)  e_d  = 1'b0;
        if (dec_wr_e)   e_d  = alu_e_out;
        if (dec_is_skip) begin
          case (op_q)
            AC_OP_SPA: skip_d = ~ac_q[Msb];
            AC_OP_SNA: skip_d = ac_q[Msb];
            AC_OP_SZA: skip_d = (ac_q == '0);
            AC_OP_SZE: skip_d = ~e_q;
            default:   skip_d = 1'b0;
          endcase
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      op_q       <= AC_OP_NOP;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_e_in_q <= 1'b0;
      alu_func_q <= FUNCWIDTH'(NO_FUNC);
      ac_q       <= '0;
      e_q        <= 1'b0;
      skip_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_e_in_q <= alu_e_in_d;
      alu_func_q <= alu_func_d;
      ac_q       <= ac_d;
      e_q        <= e_d;
      skip_q     <= skip_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign done      = (state_q == StDone);
  assign skip      = skip_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_e_in  = alu_e_in_q;
  assign alu_func  = alu_func_q;
  assign ac        = ac_q;
  assign e         = e_q;

endmodule

// File: tb/tb_mano_ac_exec.sv
// Directed self-checking bench for mano_ac_exec with a behavioural ALU model.
module tb_mano_ac_exec;
  import mano_ac_exec_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [15:0] req_dr;
  logic [15:0] alu_a, alu_b, alu_z, ac;
  logic        alu_e_in, alu_e_out, e, done, skip;
  logic [3:0]  alu_func;
`ifdef MANO_AC_OVF_FLAG_EN
  logic        ovf, ovf_clr;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Values captured by run_op: x_* during EXEC, d_* during DONE
  logic        x_done, x_skip, d_done, d_skip;
  logic [3:0]  x_func;
  logic [15:0] x_a, x_b;

  always #5 clk = ~clk;

  mano_ac_exec dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_dr    (req_dr),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_e_in  (alu_e_in),
    .alu_func  (alu_func),
    .alu_z     (alu_z),
    .alu_e_out (alu_e_out),
    .ac        (ac),
    .e         (e),
    .done      (done),
`ifdef MANO_AC_OVF_FLAG_EN
    .ovf_clr   (ovf_clr),
    .ovf       (ovf),
`endif
    .skip      (skip)
  );

  // ALU model; fields a func does not define carry junk that must be ignored
  always_comb begin
    alu_z     = 16'hDEAD;
    alu_e_out = 1'b1;
    case (alu_func)
      AND_FUNC:    alu_z = alu_a & alu_b;
      ADD_FUNC:    {alu_e_out, alu_z} = {1'b0, alu_a} + {1'b0, alu_b};
      PASSDR_FUNC: alu_z = alu_a;
      CMA_FUNC:    alu_z = ~alu_b;
      CME_FUNC:    alu_e_out = ~alu_e_in;
      CIR_FUNC:    begin alu_z = {alu_e_in, alu_b[15:1]}; alu_e_out = alu_b[0]; end
      CIL_FUNC:    begin alu_z = {alu_b[14:0], alu_e_in}; alu_e_out = alu_b[15]; end
      default: ;
    endcase
  end

  // Issue one op from IDLE and stop at the middle of its DONE cycle
  task automatic run_op(input logic [3:0] op, input logic [15:0] dr);
    int guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 10) begin
      n_vec++; n_err++;
      $display("FAIL ready_timeout got req_ready=%b want 1", req_ready);
    end
    req_valid = 1'b1; req_op = op; req_dr = dr;
    @(negedge clk);
    req_valid = 1'b0;
    x_done = done; x_skip = skip; x_func = alu_func; x_a = alu_a; x_b = alu_b;
    @(negedge clk);
    d_done = done; d_skip = skip;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_op = 4'd0; req_dr = 16'h0;
`ifdef MANO_AC_OVF_FLAG_EN
    ovf_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    n_vec++; if (ac !== 16'h0000) begin n_err++; $display("FAIL reset_ac got %h want 0000", ac); end
    n_vec++; if (e !== 1'b0) begin n_err++; $display("FAIL reset_e got %b want 0", e); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    n_vec++; if (skip !== 1'b0) begin n_err++; $display("FAIL reset_skip got %b want 0", skip); end
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", req_ready); end
    n_vec++; if (alu_func !== 4'd0) begin n_err++; $display("FAIL reset_func got %h want 0", alu_func); end
    n_vec++; if ({alu_a, alu_b, alu_e_in} !== 33'h0) begin
      n_err++; $display("FAIL reset_alu_in got %h/%h/%b want 0", alu_a, alu_b, alu_e_in);
    end
`ifdef MANO_AC_OVF_FLAG_EN
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", ovf); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_add();
    run_op(AC_OP_LDA, 16'hFFFF);
    run_op(AC_OP_CLE, 16'h0000);
    run_op(AC_OP_ADD, 16'h0001);
    n_vec++; if (x_func !== 4'd2) begin n_err++; $display("FAIL add_func got %h want 2", x_func); end
    n_vec++; if (x_a !== 16'h0001 || x_b !== 16'hFFFF) begin
      n_err++; $display("FAIL add_operands got %h/%h want 0001/ffff", x_a, x_b);
    end
    n_vec++; if (x_done !== 1'b0) begin n_err++; $display("FAIL add_done_exec got %b want 0", x_done); end
    n_vec++; if (d_done !== 1'b1) begin n_err++; $display("FAIL add_done got %b want 1", d_done); end
    n_vec++; if (ac !== 16'h0000) begin n_err++; $display("FAIL add_ac got %h want 0000", ac); end
    n_vec++; if (e !== 1'b1) begin n_err++; $display("FAIL add_e got %b want 1", e); end
    @(negedge clk);
    n_vec++; if (done !== 1'b0 || req_ready !== 1'b1) begin
      n_err++; $display("FAIL add_after got done=%b ready=%b want 0/1", done, req_ready);
    end
    n_vec++; if (alu_func !== 4'd0) begin n_err++; $display("FAIL add_func_idle got %h want 0", alu_func); end
  endtask

  task automatic test_rotate();
    run_op(AC_OP_LDA, 16'h8001);
    run_op(AC_OP_CLE, 16'h0000);
    run_op(AC_OP_CIL, 16'h0000);
    n_vec++; if ({e, ac} !== 17'h10002) begin n_err++; $display("FAIL cil got e=%b ac=%h want 1/0002", e, ac); end
    run_op(AC_OP_CIR, 16'h0000);
    n_vec++; if ({e, ac} !== 17'h08001) begin n_err++; $display("FAIL cir got e=%b ac=%h want 0/8001", e, ac); end
  endtask

  task automatic test_logic();
    run_op(AC_OP_CLE, 16'h0000);
    run_op(AC_OP_LDA, 16'hF0F0);
    n_vec++; if ({e, ac} !== 17'h0F0F0) begin n_err++; $display("FAIL lda got e=%b ac=%h want 0/f0f0", e, ac); end
    run_op(AC_OP_AND, 16'h0FF0);
    n_vec++; if ({e, ac} !== 17'h000F0) begin n_err++; $display("FAIL and got e=%b ac=%h want 0/00f0", e, ac); end
    run_op(AC_OP_CMA, 16'h0000);
    n_vec++; if (ac !== 16'hFF0F) begin n_err++; $display("FAIL cma got %h want ff0f", ac); end
    run_op(AC_OP_CME, 16'h0000);
    n_vec++; if ({e, ac} !== 17'h1FF0F) begin n_err++; $display("FAIL cme got e=%b ac=%h want 1/ff0f", e, ac); end
    run_op(AC_OP_CLA, 16'h1234);
    n_vec++; if ({e, ac} !== 17'h10000) begin n_err++; $display("FAIL cla got e=%b ac=%h want 1/0000", e, ac); end
    run_op(AC_OP_NOP, 16'h5555);
    run_op(4'd15, 16'hAAAA);
    n_vec++; if ({e, ac} !== 17'h10000) begin n_err++; $display("FAIL nop got e=%b ac=%h want 1/0000", e, ac); end
    n_vec++; if (d_done !== 1'b1 || d_skip !== 1'b0) begin
      n_err++; $display("FAIL nop_done got done=%b skip=%b want 1/0", d_done, d_skip);
    end
  endtask

  task automatic test_inc_skip();
    run_op(AC_OP_LDA, 16'hFFFF);
    run_op(AC_OP_CLE, 16'h0000);
    run_op(AC_OP_INC, 16'h7777);
    n_vec++; if (x_a !== 16'h0001) begin n_err++; $display("FAIL inc_a got %h want 0001", x_a); end
    n_vec++; if ({e, ac} !== 17'h00000) begin n_err++; $display("FAIL inc got e=%b ac=%h want 0/0000", e, ac); end
    run_op(AC_OP_SZA, 16'h0000);
    n_vec++; if (x_skip !== 1'b0) begin n_err++; $display("FAIL sza_early got %b want 0", x_skip); end
    n_vec++; if (d_skip !== 1'b1 || d_done !== 1'b1) begin
      n_err++; $display("FAIL sza got skip=%b done=%b want 1/1", d_skip, d_done);
    end
    @(negedge clk);
    n_vec++; if (skip !== 1'b0) begin n_err++; $display("FAIL sza_late got %b want 0", skip); end
    run_op(AC_OP_SNA, 16'h0000);
    n_vec++; if (d_skip !== 1'b0) begin n_err++; $display("FAIL sna got %b want 0", d_skip); end
    run_op(AC_OP_SPA, 16'h0000);
    n_vec++; if (d_skip !== 1'b1) begin n_err++; $display("FAIL spa got %b want 1", d_skip); end
    run_op(AC_OP_SZE, 16'h0000);
    n_vec++; if (d_skip !== 1'b1) begin n_err++; $display("FAIL sze0 got %b want 1", d_skip); end
    run_op(AC_OP_CMA, 16'h0000);
    run_op(AC_OP_SNA, 16'h0000);
    n_vec++; if (d_skip !== 1'b1) begin n_err++; $display("FAIL sna_neg got %b want 1", d_skip); end
    run_op(AC_OP_CME, 16'h0000);
    run_op(AC_OP_SZE, 16'h0000);
    n_vec++; if (d_skip !== 1'b0) begin n_err++; $display("FAIL sze1 got %b want 0", d_skip); end
  endtask

  task automatic test_back_to_back();
    int n_acc = 0;
    int acc_cyc[3];
    logic [15:0] ac_mid = 16'h0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (n_acc == 0) begin req_valid = 1'b1; req_op = AC_OP_LDA; req_dr = 16'h1234; end
      else if (n_acc == 1) begin req_valid = 1'b1; req_op = AC_OP_CMA; req_dr = 16'h0000; end
      else req_valid = 1'b0;
      if (req_valid && req_ready) begin
        if (n_acc == 1) ac_mid = ac;
        if (n_acc < 3) acc_cyc[n_acc] = c;
        n_acc++;
      end
    end
    req_valid = 1'b0;
    n_vec++; if (n_acc !== 2) begin n_err++; $display("FAIL b2b_count got %0d want 2", n_acc); end
    n_vec++; if (n_acc >= 2 && acc_cyc[1] - acc_cyc[0] != 3) begin
      n_err++; $display("FAIL b2b_spacing got %0d want 3", acc_cyc[1] - acc_cyc[0]);
    end
    n_vec++; if (ac_mid !== 16'h1234) begin n_err++; $display("FAIL b2b_lda got %h want 1234", ac_mid); end
    n_vec++; if (ac !== 16'hEDCB) begin n_err++; $display("FAIL b2b_cma got %h want edcb", ac); end
  endtask

  task automatic test_reset_abort();
    logic saw_done = 1'b0;
    run_op(AC_OP_LDA, 16'h0003);
    run_op(AC_OP_CLE, 16'h0000);
    @(negedge clk);
    req_valid = 1'b1; req_op = AC_OP_ADD; req_dr = 16'h0005;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++; if ({e, ac} !== 17'h0) begin n_err++; $display("FAIL abort_acc got e=%b ac=%h want 0/0000", e, ac); end
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL abort_ready got %b want 1", req_ready); end
    for (int i = 0; i < 4; i++) begin
      if (done) saw_done = 1'b1;
      @(negedge clk);
    end
    n_vec++; if (saw_done !== 1'b0) begin n_err++; $display("FAIL abort_done got %b want 0", saw_done); end
    n_vec++; if ({e, ac} !== 17'h0) begin n_err++; $display("FAIL abort_hold got e=%b ac=%h want 0/0000", e, ac); end
  endtask

`ifdef MANO_AC_OVF_FLAG_EN
  task automatic test_ovf();
    run_op(AC_OP_LDA, 16'h7FFF);
    run_op(AC_OP_ADD, 16'h0001);
    n_vec++; if (ac !== 16'h8000) begin n_err++; $display("FAIL ovf_ac got %h want 8000", ac); end
    n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set got %b want 1", ovf); end
    run_op(AC_OP_NOP, 16'h0000);
    n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", ovf); end
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clr got %b want 0", ovf); end
    // 0x8000 + 0x8000 overflows; clear held across the writeback edge must lose
    ovf_clr = 1'b1;
    run_op(AC_OP_ADD, 16'h8000);
    ovf_clr = 1'b0;
    n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set_wins got %b want 1", ovf); end
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_rotate();
    test_logic();
    test_inc_skip();
    test_back_to_back();
    test_reset_abort();
`ifdef MANO_AC_OVF_FLAG_EN
    test_ovf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
